hazard_controller: RTL and testbench
====================================

// Module: hazard_controller
// PURPOSE
//  Pipeline hazard controller: generates the stall and squash strobes consumed by the decode stage.
//  Keeps a scoreboard of destination registers in flight between decode and writeback.
//  Stalls on RAW hazards and injects a bubble into the decode output latches.
//  Flushes fetch/decode for a fixed number of cycles after a taken jump. Sits beside decode; one instance per core.
// PARAMETERS
//  DEPTH         3   scoreboard entries (EX, MEM, WB); entry 0 = youngest
//  FLUSH_CYCLES  2   cycles squash is held for a taken jump (>=1)
//  CNT_W         16  width of stall_count
// PORTS
//  clk          in   1      clock; all state on rising edge
//  rst          in   1      synchronous reset, active-high
//  a0           in   5      decode rs1 index
//  a1           in   5      decode rs2 index
//  use_rs1      in   1      decode instr reads a0
//  use_rs2      in   1      decode instr reads a1
//  a2_hazard    in   5      decode rd index (already zeroed by squash)
//  dec_reg_wr   in   1      decode instr writes rd
//  dec_is_load  in   1      decode instr is a load (result available at MEM)
//  jmp_taken    in   1      execute resolved a taken jump/branch this cycle
//  stall        out  1      hold fetch PC and fetch/decode latch
//  squash       out  1      zero everything decode passes to its output latches (bubble)
//  stall_count  out  CNT_W  saturating count of hazard-stall cycles
// BEHAVIOUR
//  Reset: all scoreboard entries invalid, FSM=RUN, flush counter 0, stall=0, squash=0, stall_count=0.
//  Scoreboard entry = {valid, rd[4:0], is_load}. It shifts every cycle; the pipeline beyond decode never freezes.
//   entry[0] <= {dec_reg_wr & (a2_hazard!=0) & ~squash, a2_hazard, dec_is_load}.
//   entry[i] <= entry[i-1]; entry[DEPTH-1] retires.
//  Match(src) = src!=0 & any valid entry[i].rd==src. Register x0 never causes a hazard.
//  hazard = (use_rs1 & Match(a0)) | (use_rs2 & Match(a1)); combinational, same cycle.
//  FSM states:
//   RUN:   jmp_taken -> squash=1, stall=0, flush counter = FLUSH_CYCLES-1.
//          Next state: FLUSH if FLUSH_CYCLES>1, else RUN.
//          Otherwise stall=hazard, squash=hazard.
//   FLUSH: squash=1, stall=0, counter decrements; at 0 -> RUN.
//          A new jmp_taken in FLUSH reloads the counter to FLUSH_CYCLES-1.
//  Priority: jmp_taken/FLUSH over hazard. The stalled instruction is younger than the branch and is discarded.
//  stall and squash are combinational from FSM state, scoreboard and decode inputs; zero added latency.
//  Stall duration for a dependent instruction directly behind its producer: DEPTH cycles (no forwarding).
//  stall_count: +1 on each cycle with stall=1; saturates at 2^CNT_W-1, no wrap.
//  Reset asserted mid-stall or mid-flush: next cycle all outputs at reset values, in-flight entries dropped.
// CONFIGURATION
//  HAZARD_FWD_EN defined: execute/memory forwarding exists.
//   Match is restricted to entry[0] with is_load=1 (load-use only).
//   A load followed by a dependent instruction stalls exactly 1 cycle; ALU-to-ALU dependences never stall.
//  HAZARD_FWD_EN undefined: full-scoreboard match as above.
// TESTING
//  1. Reset held 2 cycles, then idle inputs -> stall=0, squash=0, stall_count=0.
//  2. Macro off: addi x5 then add x6,x5,x0 back-to-back -> stall=squash=1 for 3 cycles, then 0; stall_count=3.
//  3. Producer rd=0 (x0), consumer a0=0 use_rs1=1 -> stall never asserts.
//  4. jmp_taken pulse 1 cycle while hazard=1 -> stall=0, squash=1 for 2 cycles (FLUSH_CYCLES=2).
//     The scoreboard receives no entry for the squashed instruction.
//  5. HAZARD_FWD_EN: lw x7 then add x8,x7,x7 -> 1 stall cycle.
//     Same sequence with an addi producer -> 0 stall cycles.
//  6. Force stall_count to 16'hFFFE, hold a hazard 3 cycles -> stall_count=16'hFFFF and stays there.
//     Then assert rst mid-stall -> all outputs 0 on the following cycle.

Source files
------------

// File: rtl/hazard_controller_if.sv
// hazard_controller_if: decode-side hazard signals with decode (master) and controller (slave) views
interface hazard_controller_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       a0;
  logic [4:0]       a1;
  logic             use_rs1;
  logic             use_rs2;
  logic [4:0]       a2_hazard;
  logic             dec_reg_wr;
  logic             dec_is_load;
  logic             jmp_taken;
  logic             stall;
  logic             squash;
  logic [CNT_W-1:0] stall_count;
  modport master (
    output a0, a1, use_rs1, use_rs2, a2_hazard, dec_reg_wr, dec_is_load, jmp_taken,
    input  stall, squash, stall_count
  );
  modport slave (
    input  a0, a1, use_rs1, use_rs2, a2_hazard, dec_reg_wr, dec_is_load, jmp_taken,
    output stall, squash, stall_count
  );
endinterface

// File: rtl/hazard_controller.sv
// hazard_controller: RAW scoreboard stall/squash and jump flush for decode; HAZARD_FWD_EN limits hazards to load-use
module hazard_controller #(
  parameter int DEPTH        = 3,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input logic          clk,
  input logic          rst,
  hazard_controller_if.slave hz
);
  localparam int FW = FLUSH_CYCLES > 1 ? $clog2(FLUSH_CYCLES) : 1;
  typedef enum logic {RUN, FLUSH} state_t;
  state_t           state;
  logic [FW-1:0]    fcnt;
  logic [DEPTH-1:0] vld;
  logic [DEPTH-1:0] ld;
  logic [4:0]       rd [DEPTH];
  logic [DEPTH-1:0] elig;
  logic             m0, m1, hazard, flush, stall, squash;
  logic [CNT_W-1:0] cnt;
  always_comb begin
    elig = vld;
`ifdef HAZARD_FWD_EN
    elig    = '0;
    elig[0] = vld[0] & ld[0];
`endif
    m0 = 1'b0;
    m1 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      m0 = m0 | (elig[i] & (rd[i] == hz.a0));
      m1 = m1 | (elig[i] & (rd[i] == hz.a1));
    end
    hazard = (hz.use_rs1 & (hz.a0 != 5'd0) & m0) | (hz.use_rs2 & (hz.a1 != 5'd0) & m1);
    flush  = (state == FLUSH) | hz.jmp_taken;
    stall  = ~flush & hazard;
    squash = flush | hazard;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= '0;
    end else begin
      for (int i = DEPTH - 1; i > 0; i--) begin
        vld[i] <= vld[i-1];
        ld[i]  <= ld[i-1];
        rd[i]  <= rd[i-1];
      end
      vld[0] <= hz.dec_reg_wr & (hz.a2_hazard != 5'd0) & ~squash;
      ld[0]  <= hz.dec_is_load;
      rd[0]  <= hz.a2_hazard;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      fcnt  <= '0;
    end else if (hz.jmp_taken) begin
      state <= FLUSH_CYCLES > 1 ? FLUSH : RUN;
      fcnt  <= FW'(FLUSH_CYCLES - 1);
    end else if (state == FLUSH) begin
      state <= fcnt <= FW'(1) ? RUN : FLUSH;
      fcnt  <= fcnt - FW'(1);
    end
  end
  always_ff @(posedge clk) begin
    if (rst) cnt <= '0;
    else if (stall && !(&cnt)) cnt <= cnt + CNT_W'(1);
  end
  assign hz.stall       = stall;
  assign hz.squash      = squash;
  assign hz.stall_count = cnt;
endmodule

// File: tb/tb_hazard_controller.sv
// tb_hazard_controller: random and directed stimulus against a register-busy-time reference model
module tb_hazard_controller;
  localparam int DEPTH = 3;
  localparam int FC    = 2;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  logic [4:0] a0, a1, rd;
  logic       u1, u2, wr, ld, jmp;
  hazard_controller_if #(16) hz();
  hazard_controller_if #(2)  hs();
  assign hz.a0 = a0;
  assign hz.a1 = a1;
  assign hz.use_rs1 = u1;
  assign hz.use_rs2 = u2;
  assign hz.a2_hazard = rd;
  assign hz.dec_reg_wr = wr;
  assign hz.dec_is_load = ld;
  assign hz.jmp_taken = jmp;
  assign hs.a0 = a0;
  assign hs.a1 = a1;
  assign hs.use_rs1 = u1;
  assign hs.use_rs2 = u2;
  assign hs.a2_hazard = rd;
  assign hs.dec_reg_wr = wr;
  assign hs.dec_is_load = ld;
  assign hs.jmp_taken = jmp;
  hazard_controller #(.DEPTH(DEPTH), .FLUSH_CYCLES(FC), .CNT_W(16)) dut (.clk(clk), .rst(rst), .hz(hz));
  hazard_controller #(.DEPTH(DEPTH), .FLUSH_CYCLES(FC), .CNT_W(2)) dut_s (.clk(clk), .rst(rst), .hz(hs));
  int n_chk = 0;
  int n_fail = 0;
  int busy [32];
  int last_jmp, cyc, scnt, n;
  logic st;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  task automatic model_reset();
    for (int i = 0; i < 32; i++) busy[i] = -1000;
    last_jmp = -1000;
    scnt = 0;
  endtask
  task automatic step(input logic r, input logic [4:0] x0, input logic [4:0] x1, input logic e1,
                      input logic e2, input logic [4:0] d, input logic w, input logic l,
                      input logic j, output logic s);
    logic h, fl, es, eq;
    @(posedge clk);
    #1;
    rst = r; a0 = x0; a1 = x1; u1 = e1; u2 = e2; rd = d; wr = w; ld = l; jmp = j;
    #1;
    h  = (e1 && x0 != 0 && cyc <= busy[x0]) || (e2 && x1 != 0 && cyc <= busy[x1]);
    fl = j || (cyc - last_jmp < FC);
    es = !fl && h;
    eq = fl || h;
    check("stall", {31'd0, hz.stall}, {31'd0, es});
    check("squash", {31'd0, hz.squash}, {31'd0, eq});
    check("stall_count", {16'd0, hz.stall_count}, scnt > 65535 ? 32'd65535 : 32'(scnt));
    check("stall_count_sat2", {30'd0, hs.stall_count}, scnt > 3 ? 32'd3 : 32'(scnt));
    if (r) begin
      model_reset();
    end else begin
      if (j) last_jmp = cyc;
      if (w && d != 0 && !eq) begin
`ifdef HAZARD_FWD_EN
        if (l && busy[d] < cyc + 1) busy[d] = cyc + 1;
`else
        if (busy[d] < cyc + DEPTH) busy[d] = cyc + DEPTH;
`endif
      end
      if (es) scnt++;
    end
    cyc++;
    s = es;
  endtask
  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, st);
  endtask
  initial begin
    cyc = 0;
    model_reset();
    rst = 1; a0 = 0; a1 = 0; u1 = 0; u2 = 0; rd = 0; wr = 0; ld = 0; jmp = 0;
    repeat (2) @(posedge clk);
    idle(2);
    step(0, 0, 0, 0, 0, 5, 1, 0, 0, st);
    n = 0;
    for (int i = 0; i < 5; i++) begin
      step(0, 5, 0, 1, 1, 6, 1, 0, 0, st);
      n += int'(st);
    end
`ifdef HAZARD_FWD_EN
    check("alu_alu_stall_len", n, 0);
`else
    check("raw_stall_len", n, 3);
`endif
    idle(4);
    step(0, 0, 0, 0, 0, 0, 1, 0, 0, st);
    n = 0;
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 1, 0, 6, 1, 0, 0, st);
      n += int'(st);
    end
    check("x0_never_stalls", n, 0);
    idle(4);
    step(0, 0, 0, 0, 0, 5, 1, 0, 0, st);
    step(0, 5, 0, 1, 0, 9, 1, 0, 1, st);
    check("jmp_over_hazard_stall", {31'd0, st}, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, st);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, st);
    check("flush_ended_squash", {31'd0, hz.squash}, 0);
    step(0, 9, 0, 1, 0, 0, 0, 0, 0, st);
    check("squashed_not_scoreboarded", {31'd0, st}, 0);
    idle(4);
    step(0, 0, 0, 0, 0, 7, 1, 1, 0, st);
    n = 0;
    for (int i = 0; i < 5; i++) begin
      step(0, 7, 7, 1, 1, 8, 1, 0, 0, st);
      n += int'(st);
    end
`ifdef HAZARD_FWD_EN
    check("load_use_stall_len", n, 1);
`else
    check("load_raw_stall_len", n, 3);
`endif
    idle(4);
    step(0, 0, 0, 0, 0, 3, 1, 0, 0, st);
    step(0, 3, 0, 1, 0, 4, 1, 0, 0, st);
    step(1, 3, 0, 1, 0, 4, 1, 0, 0, st);
    step(0, 3, 0, 1, 0, 4, 1, 0, 0, st);
    check("reset_drops_stall", {31'd0, hz.stall}, 0);
    check("reset_clears_count", {16'd0, hz.stall_count}, 0);
    for (int i = 0; i < 4000; i++) begin
      step($urandom_range(0, 99) == 0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           1'($urandom), 1'($urandom), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 3) != 0),
           1'($urandom), $urandom_range(0, 9) == 0, st);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
